// File: rtl/modem_pkg.sv
// Shared modem constants and types.
// Used by the modulator, the IF streamer and the downstream link.
package modem_pkg;

    localparam int MODEM_SAMPLE_W = 12;
    localparam int MODEM_WORD_W   = 2 * MODEM_SAMPLE_W;
    localparam int MODEM_DEPTH    = 16;

    typedef logic [MODEM_WORD_W-1:0] word_t;

    typedef enum logic {
        PK_LOW,
        PK_HIGH
    } pack_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// The extra pointer MSB separates full from empty.
module sync_fifo_fwft #(
    parameter int W     = 24,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // A pop frees a slot in the same cycle, so full+pop still accepts.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_sample_streamer.sv
// Packs IF sample pairs into words, buffers them in a FWFT FIFO
// and streams them out with overflow accounting.
module if_sample_streamer
    import modem_pkg::*;
#(
    parameter int SAMPLE_W = MODEM_SAMPLE_W,
    parameter int DEPTH    = MODEM_DEPTH,
    parameter int CNT_W    = 16
) (
    input  logic                   ip_clock,
    input  logic                   ip_reset,
    input  logic                   ip_enable,
    input  logic [SAMPLE_W-1:0]    ip_if,
    input  logic                   ip_if_valid,
    input  logic                   ip_ready,
    input  logic                   ip_clear_status,
    output logic [2*SAMPLE_W-1:0]  op_word,
    output logic                   op_valid,
    output logic [$clog2(DEPTH):0] op_level,
    output logic                   op_overflow,
    output logic [CNT_W-1:0]       op_drop_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    pack_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] low_q, low_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic drop;

    assign pop  = ~empty & ip_ready;
    assign drop = push & full & ~pop;

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        push    = 1'b0;
        unique case (state_q)
            PK_LOW: begin
                if (ip_enable && ip_if_valid) begin
                    low_d   = ip_if;
                    state_d = PK_HIGH;
                end
            end
            PK_HIGH: begin
                // Dropping enable abandons the half pair.
                if (!ip_enable) begin
                    state_d = PK_LOW;
                end else if (ip_if_valid) begin
                    push    = 1'b1;
                    state_d = PK_LOW;
                end
            end
            default: state_d = PK_LOW;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (ip_clear_status) begin
            ovf_d = drop;
            cnt_d = drop ? CNT_ONE : '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge ip_clock) begin
        if (ip_reset) begin
            state_q <= PK_LOW;
            low_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    sync_fifo_fwft #(
        .W     (2 * SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ip_clock),
        .rst   (ip_reset),
        .push  (push),
        .pop   (pop),
        .wdata ({ip_if, low_q}),
        .rdata (op_word),
        .full  (full),
        .empty (empty),
        .level (op_level)
    );

    assign op_valid      = ~empty;
    assign op_overflow   = ovf_q;
    assign op_drop_count = cnt_q;

endmodule

// File: doc/if_sample_streamer.md
Name: if_sample_streamer

Overview:
- Sits directly downstream of the QPSK modulator. Consumes its 12-bit signed IF sample stream, one sample per clock when qualified.
- Packs consecutive sample pairs into 24-bit words and buffers them in a FWFT FIFO.
- Presents the words on a valid/ready stream to the DAC/host link, with overflow accounting.

Parameters:
- SAMPLE_W, 12, width of one signed IF sample.
- DEPTH, 16, FIFO depth in packed words; power of two, >= 4.
- CNT_W, 16, width of the drop counter.

Ports:
- ip_clock  input  1  system clock; all logic on rising edge.
- ip_reset  input  1  synchronous, active-high reset.
- ip_enable  input  1  streamer enable; low = no capture.
- ip_if  input  SAMPLE_W  signed IF sample from the modulator.
- ip_if_valid  input  1  sample qualifier; tie high for one-sample-per-clock sources.
- ip_ready  input  1  downstream ready.
- ip_clear_status  input  1  one-cycle pulse; clears op_overflow and op_drop_count.
- op_word  output  2*SAMPLE_W  packed word: {second sample, first sample}.
- op_valid  output  1  op_word holds a valid word.
- op_level  output  clog2(DEPTH)+1  FIFO occupancy in words.
- op_overflow  output  1  sticky: at least one word dropped.
- op_drop_count  output  CNT_W  words dropped; saturates at all-ones.

Behaviour:
- Reset (ip_reset=1 at a rising edge): FIFO empty. Pending half cleared. op_valid=0, op_word=0, op_level=0, op_overflow=0, op_drop_count=0. Reset mid-burst discards all buffered words and any pending half.
- Capture condition: ip_enable & ip_if_valid at a rising edge.
- Packer FSM, two states:
  - LOW: on capture, latch ip_if into the low half and go to HIGH.
  - HIGH: on capture, form {ip_if, low} and issue one push; go to LOW.
  - ip_enable low in HIGH: discard the pending half and return to LOW. Keeps pairs aligned to enable bursts.
  - ip_if_valid low with ip_enable high: hold state.
- Samples are passed unmodified; no sign extension or truncation.
- Push and pop:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (full + simultaneous pop => accept).
  - Otherwise the word is dropped: op_overflow<=1 and op_drop_count increments, saturating.
  - After a drop the packer continues in LOW; the next two samples form a new pair.
- Output: FWFT. op_valid = FIFO not empty. Pop when op_valid & ip_ready. op_word is stable while op_valid=1 and ip_ready=0.
- Latency: the push edge writes the word; op_valid rises after that same edge when the FIFO was empty. First word is therefore visible 2 edges after the first captured sample.
- op_level: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither. Range 0..DEPTH.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer MSB.
- ip_clear_status:
  - Clears op_overflow and op_drop_count.
  - If a drop occurs in the same cycle, the result is op_overflow=1 and op_drop_count=1.
  - Does not affect FIFO contents.
- ip_ready is ignored when op_valid=0; a pop of an empty FIFO never occurs.

Decomposition:
- Shared package (modem_pkg):
  - SAMPLE_W=12 and WORD_W=24 constants.
  - A packed-word typedef.
  - Default DEPTH constant, shared with the modulator and downstream link.
- One sub-module: sync_fifo_fwft (parameterized width/depth; push/pop/full/empty/level). Reusable by the future demodulator path.
- Packer FSM and status counters live in the top.

Test Plan:
- Reset then stream: ip_enable=1, ip_if_valid=1, ip_ready=1; samples 0x001,0x002,0x003,0x004 -> words 0x002001 then 0x004003; op_valid first high 2 edges after the first sample; op_level never exceeds 1.
- Backpressure fill: ip_ready=0; 2*DEPTH+4 samples (0x800,0x801,...) -> op_level=16; op_overflow=1; op_drop_count=2; op_word=0x801800 held stable. Then ip_ready=1 drains 16 words in order.
- Full with simultaneous pop: FIFO full; ip_ready=1 on the push cycle -> word accepted; op_level stays 16; no drop counted.
- Enable break mid-pair: samples 0x0AA, then ip_enable=0 for 1 cycle, then 0x0BB, 0x0CC -> only word 0x0CC0BB emitted; 0x0AA discarded.
- Status clear: force 3 drops, then pulse ip_clear_status -> op_overflow=0, op_drop_count=0. Clear coincident with a drop -> op_overflow=1, op_drop_count=1.
- Reset mid-operation: 5 words buffered; assert ip_reset for 1 cycle -> op_valid=0, op_level=0 on the next cycle; the following pair 0x123,0x456 yields 0x456123.
